// File: rtl/alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : alu_result_stage
// Description : Result stage after the 8-bit logic unit. Accepts one
//               operation per handshake, waits a fixed settle time, then
//               latches the result and the zero/sign/carry condition flags
//               and holds them until the data-bus side takes them.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module alu_result_stage #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] fn,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] logic_in,
  output logic [7:0] result,
  output logic       result_valid,
  input  logic       result_ready,
  output logic       cond_zero,
  output logic       cond_sign,
  output logic       cond_carry
);

  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_settle = 2'd1;
  localparam logic [1:0] c_hold   = 2'd2;

  localparam logic [2:0] c_fn_add = 3'b000;
  localparam logic [2:0] c_fn_inc = 3'b001;
  localparam logic [2:0] c_fn_shl = 3'b110;
  localparam logic [2:0] c_fn_clr = 3'b111;

  // Counter reloads with SETTLE_CYCLES-1 so the latch edge lands exactly
  // SETTLE_CYCLES edges after the accept edge.
  localparam logic [3:0] c_cnt_init = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fn_q, fn_d;
  logic [7:0] b_q, b_d;
  logic [7:0] c_q, c_d;
  logic [7:0] result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic       zero_q, zero_d;
  logic       sign_q, sign_d;
  logic       carry_q, carry_d;

  logic [8:0] w_calc;

  assign op_ready     = (state_q == c_idle);
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign cond_zero    = zero_q;
  assign cond_sign    = sign_q;
  assign cond_carry   = carry_q;

  // Result of the latched operation; bit 8 is the carry out.
  // logic_in is taken live because upstream holds it for the latched fn.
  always_comb begin
    w_calc = {1'b0, logic_in};
    case (fn_q)
      c_fn_add: w_calc = {1'b0, b_q} + {1'b0, c_q};
      c_fn_inc: w_calc = {1'b0, b_q} + 9'd1;
      c_fn_shl: w_calc = {1'b0, b_q[6:0], b_q[7]};
      c_fn_clr: w_calc = 9'd0;
      default:  w_calc = {1'b0, logic_in};
    endcase
  end

  // Handshake FSM, settle counter and result/flag latching.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    fn_d           = fn_q;
    b_d            = b_q;
    c_d            = c_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    zero_d         = zero_q;
    sign_d         = sign_q;
    carry_d        = carry_q;
    case (state_q)
      c_idle: begin
        if (op_valid) begin
          fn_d    = fn;
          b_d     = b;
          c_d     = c;
          cnt_d   = c_cnt_init;
          state_d = c_settle;
        end
      end
      c_settle: begin
        if (cnt_q == 4'd0) begin
          result_d       = w_calc[7:0];
          carry_d        = w_calc[8];
          zero_d         = (w_calc[7:0] == 8'd0);
          sign_d         = w_calc[7];
          result_valid_d = 1'b1;
          state_d        = c_hold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      c_hold: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          state_d        = c_idle;
        end
      end
      default: state_d = c_idle;
    endcase
  end

  // State registers with synchronous reset; an in-flight operation is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= c_idle;
      cnt_q          <= 4'd0;
      fn_q           <= 3'd0;
      b_q            <= 8'd0;
      c_q            <= 8'd0;
      result_q       <= 8'd0;
      result_valid_q <= 1'b0;
      zero_q         <= 1'b0;
      sign_q         <= 1'b0;
      carry_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      fn_q           <= fn_d;
      b_q            <= b_d;
      c_q            <= c_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      zero_q         <= zero_d;
      sign_q         <= sign_d;
      carry_q        <= carry_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_alu_result_stage
// Description : Directed bench for alu_result_stage, default settle time and
//               a single-cycle settle build side by side.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_alu_result_stage;

  logic       clk;
  logic       reset;
  logic [2:0] fn;
  logic [7:0] b;
  logic [7:0] c;
  logic [7:0] logic_in;

  logic       op_valid, op_ready, result_valid, result_ready;
  logic [7:0] result;
  logic       cz, cs, cc;

  logic       op_valid1, op_ready1, result_valid1, result_ready1;
  logic [7:0] result1;
  logic       cz1, cs1, cc1;

  int total;
  int bad;

  alu_result_stage #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready),
    .fn(fn), .b(b), .c(c), .logic_in(logic_in),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .cond_zero(cz), .cond_sign(cs), .cond_carry(cc)
  );

  alu_result_stage #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .op_valid(op_valid1), .op_ready(op_ready1),
    .fn(fn), .b(b), .c(c), .logic_in(logic_in),
    .result(result1), .result_valid(result_valid1), .result_ready(result_ready1),
    .cond_zero(cz1), .cond_sign(cs1), .cond_carry(cc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run one operation through the 4-cycle instance, check latency and the
  // latched values, then release it with a single result_ready pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [7:0] bb,
                        input logic [7:0] cv, input logic [7:0] li, input logic [7:0] er,
                        input logic ez, input logic es, input logic ec);
    op_valid = 1'b1; fn = f; b = bb; c = cv; logic_in = li;
    step();                        // accept edge (edge 0)
    op_valid = 1'b0;
    chk({tag, "_busy"}, {7'd0, op_ready}, 8'd0);
    step(); step(); step();        // edges 1..3
    chk({tag, "_early"}, {7'd0, result_valid}, 8'd0);
    step();                        // edge 4: latch
    chk({tag, "_valid"}, {7'd0, result_valid}, 8'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_z"}, {7'd0, cz}, {7'd0, ez});
    chk({tag, "_s"}, {7'd0, cs}, {7'd0, es});
    chk({tag, "_c"}, {7'd0, cc}, {7'd0, ec});
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_released"}, {7'd0, result_valid}, 8'd0);
    chk({tag, "_idle"}, {7'd0, op_ready}, 8'd1);
    chk({tag, "_kept"}, result, er);
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; op_valid = 1'b0; op_valid1 = 1'b0;
    result_ready = 1'b0; result_ready1 = 1'b0;
    fn = 3'd0; b = 8'd0; c = 8'd0; logic_in = 8'd0;
    step(); step(); step();
    reset = 1'b0;
    step();
    chk("rst_ready", {7'd0, op_ready}, 8'd1);
    chk("rst_valid", {7'd0, result_valid}, 8'd0);
    chk("rst_result", result, 8'h00);
    chk("rst_flags", {5'd0, cz, cs, cc}, 8'd0);

    // Reset during SETTLE discards the operation.
    op_valid = 1'b1; fn = 3'b000; b = 8'h7F; c = 8'h01;
    step();
    op_valid = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    chk("abort_ready", {7'd0, op_ready}, 8'd1);
    step(); step(); step(); step();
    chk("abort_valid", {7'd0, result_valid}, 8'd0);
    chk("abort_result", result, 8'h00);
    chk("abort_flags", {5'd0, cz, cs, cc}, 8'd0);

    run_op("add_7f_01", 3'b000, 8'h7F, 8'h01, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0);
    run_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("inc_ff",    3'b001, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("shl_81",    3'b110, 8'h81, 8'h00, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
    run_op("xor_f0",    3'b100, 8'h0F, 8'hFF, 8'hF0, 8'hF0, 1'b0, 1'b1, 1'b0);
    run_op("add_12_34", 3'b000, 8'h12, 8'h34, 8'h00, 8'h46, 1'b0, 1'b0, 1'b0);
    run_op("and_li",    3'b010, 8'h55, 8'h0F, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0);

    // Back-pressure: park a result in HOLD while new operands are offered.
    op_valid = 1'b1; fn = 3'b000; b = 8'h12; c = 8'h34;
    step();
    op_valid = 1'b0;
    step(); step(); step(); step();
    chk("bp_valid", {7'd0, result_valid}, 8'd1);
    op_valid = 1'b1; fn = 3'b000; b = 8'h01; c = 8'h01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_res", result, 8'h46);
      chk("bp_hold_flags", {4'd0, result_valid, cz, cs, cc}, 8'b0000_1000);
      chk("bp_hold_ready", {7'd0, op_ready}, 8'd0);
    end
    result_ready = 1'b1;
    step();                        // HOLD -> IDLE; op_valid not taken here
    result_ready = 1'b0;
    chk("bp_rel_valid", {7'd0, result_valid}, 8'd0);
    chk("bp_rel_ready", {7'd0, op_ready}, 8'd1);
    step();                        // accept edge in IDLE
    op_valid = 1'b0;
    chk("bp_accept", {7'd0, op_ready}, 8'd0);
    step(); step(); step();
    chk("bp_new_early", {7'd0, result_valid}, 8'd0);
    step();
    chk("bp_new_valid", {7'd0, result_valid}, 8'd1);
    chk("bp_new_res", result, 8'h02);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;

    // Single-cycle settle build: nonzero result first, then CLR.
    op_valid1 = 1'b1; fn = 3'b000; b = 8'h7F; c = 8'h01;
    step();
    op_valid1 = 1'b0;
    chk("s1_add_early", {7'd0, result_valid1}, 8'd0);
    step();
    chk("s1_add_valid", {7'd0, result_valid1}, 8'd1);
    chk("s1_add_res", result1, 8'h80);
    result_ready1 = 1'b1;
    step();
    result_ready1 = 1'b0;
    chk("s1_idle", {7'd0, op_ready1}, 8'd1);
    op_valid1 = 1'b1; fn = 3'b111; b = 8'hAA; c = 8'h55;
    step();
    op_valid1 = 1'b0;
    chk("s1_clr_early", {7'd0, result_valid1}, 8'd0);
    step();
    chk("s1_clr_valid", {7'd0, result_valid1}, 8'd1);
    chk("s1_clr_res", result1, 8'h00);
    chk("s1_clr_flags", {5'd0, cz1, cs1, cc1}, 8'b0000_0100);
    result_ready1 = 1'b1;
    step();
    result_ready1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
